// File: rtl/comparator_sweep_driver_if.sv
// Operand/result bundle between the sweep driver and the comparator under test.
//   start                      : request a new sweep (into the driver)
//   a_out, b_out               : operands driven to the comparator
//   equal_in/greater_in/lower_in : comparator results returned to the driver
//   busy, done, pass           : sweep status
//   err_count                  : number of mismatching pairs (saturating)
//   fail_a, fail_b, fail_flags : first mismatching pair and the flags seen there
// master = driver side, slave = comparator/host side.
interface comparator_sweep_driver_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 2*WIDTH+1
);
  logic             start;
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic             equal_in;
  logic             greater_in;
  logic             lower_in;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_count;
  logic [WIDTH-1:0] fail_a;
  logic [WIDTH-1:0] fail_b;
  logic [2:0]       fail_flags;

  modport master (
    input  start, equal_in, greater_in, lower_in,
    output a_out, b_out, busy, done, pass, err_count, fail_a, fail_b, fail_flags
  );

  modport slave (
    output start, equal_in, greater_in, lower_in,
    input  a_out, b_out, busy, done, pass, err_count, fail_a, fail_b, fail_flags
  );
endinterface

// File: rtl/comparator_sweep_driver.sv
// Built-in self-test engine for an unsigned WIDTH-bit comparator.
// On start, walks every (a,b) pair (a outer, b inner, both ascending), holds
// each pair for a DRIVE settle cycle plus a CHECK sample cycle, compares the
// returned {equal,greater,lower} flags against an unsigned reference, counts
// mismatches and captures the first failing pair.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous reset, active high
//   bus  : comparator_sweep_driver_if.master (see interface for signal list)
module comparator_sweep_driver #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 2*WIDTH+1
) (
  input  logic                        clk,
  input  logic                        rst,
  comparator_sweep_driver_if.master   bus
);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_e;

  localparam logic [WIDTH-1:0] OP_MAX  = '1;
  localparam logic [CNT_W-1:0] ERR_MAX = '1;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] fail_a_q, fail_b_q;
  logic [2:0]       fail_flags_q;
  logic [CNT_W-1:0] err_q;
  logic             first_q;   // a mismatch has already been captured
  logic             busy_q, done_q;

  logic [2:0]       exp_flags, got_flags;
  logic             mismatch;
  logic             last_pair;
  logic [CNT_W-1:0] err_d;
  logic [WIDTH-1:0] a_d, b_d;

  always_comb begin
    exp_flags = {a_q == b_q, a_q > b_q, a_q < b_q};
    got_flags = {bus.equal_in, bus.greater_in, bus.lower_in};
    // Full-vector compare also catches non-one-hot comparator outputs.
    mismatch  = (got_flags != exp_flags);
    last_pair = (a_q == OP_MAX) && (b_q == OP_MAX);
    err_d     = (err_q == ERR_MAX) ? err_q : err_q + 1'b1;
    // b is the inner loop; a steps when b wraps.
    b_d       = b_q + 1'b1;
    a_d       = (b_q == OP_MAX) ? a_q + 1'b1 : a_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      fail_a_q     <= '0;
      fail_b_q     <= '0;
      fail_flags_q <= '0;
      err_q        <= '0;
      first_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            state_q      <= DRIVE;
            a_q          <= '0;
            b_q          <= '0;
            fail_a_q     <= '0;
            fail_b_q     <= '0;
            fail_flags_q <= '0;
            err_q        <= '0;
            first_q      <= 1'b0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
          end
        end
        DRIVE: begin
          // Settle cycle: operands have been stable since the previous edge.
          state_q <= CHECK;
        end
        CHECK: begin
          if (mismatch) begin
            err_q <= err_d;
            if (!first_q) begin
              first_q      <= 1'b1;
              fail_a_q     <= a_q;
              fail_b_q     <= b_q;
              fail_flags_q <= got_flags;
            end
          end
          if (last_pair) begin
            // Operands stay at the final pair while in DONE.
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= DRIVE;
            a_q     <= a_d;
            b_q     <= b_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.a_out      = a_q;
  assign bus.b_out      = b_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = done_q && (err_q == '0);
  assign bus.err_count  = err_q;
  assign bus.fail_a     = fail_a_q;
  assign bus.fail_b     = fail_b_q;
  assign bus.fail_flags = fail_flags_q;

endmodule
